// File: rtl/yj_basic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : yj_basic_pkg
// Purpose  : Shared helpers for the yj_basic signal-sync/filter blocks.
//            - clog2()        : ceiling log2, sizes the filter counter
//            - stages_legal() : synchronizer depth range check
//            - filt_legal()   : filter threshold range check
//            - edge_e/edge_of : classify a level transition
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package yj_basic_pkg;

  localparam int c_stages_min = 2;
  localparam int c_stages_max = 4;
  localparam int c_filt_min   = 0;
  localparam int c_filt_max   = 255;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_e;

  // Smallest r with 2**r >= value; clog2(1) == 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic bit stages_legal(input int stages);
    return (stages >= c_stages_min) && (stages <= c_stages_max);
  endfunction

  function automatic bit filt_legal(input int filt);
    return (filt >= c_filt_min) && (filt <= c_filt_max);
  endfunction

  function automatic edge_e edge_of(input logic cur, input logic nxt);
    if (!cur && nxt) begin
      return EDGE_RISE;
    end else if (cur && !nxt) begin
      return EDGE_FALL;
    end else begin
      return EDGE_NONE;
    end
  endfunction

endpackage : yj_basic_pkg
`default_nettype wire

// File: rtl/yj_basic_signal_sync_filter_if.sv
`default_nettype none
// ============================================================================
// Module   : yj_basic_signal_sync_filter_if
// Purpose  : Signal bundle between the raw-input producer and the
//            synchronizer/filter block.
//   en   : sample-enable tick for the filter counters (producer -> filter)
//   din  : asynchronous raw levels, NCH bits           (producer -> filter)
//   dout : filtered, synchronized levels               (filter -> consumer)
//   rise : one-cycle 0->1 pulse per channel            (filter -> consumer)
//   fall : one-cycle 1->0 pulse per channel            (filter -> consumer)
//   chg  : registered OR of rise|fall                  (filter -> consumer)
// Modports : master (drives en/din), slave (the filter block)
// Revision : 1.0 - initial release
// ============================================================================
interface yj_basic_signal_sync_filter_if #(
  parameter int NCH = 8
);
  logic           en;
  logic [NCH-1:0] din;
  logic [NCH-1:0] dout;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] fall;
  logic           chg;

  modport master (
    output en,
    output din,
    input  dout,
    input  rise,
    input  fall,
    input  chg
  );

  modport slave (
    input  en,
    input  din,
    output dout,
    output rise,
    output fall,
    output chg
  );

endinterface : yj_basic_signal_sync_filter_if
`default_nettype wire

// File: rtl/yj_basic_debounce_ch.sv
`default_nettype none
// ============================================================================
// Module   : yj_basic_debounce_ch
// Purpose  : One channel: STAGES-deep synchronizer, stability filter of FILT
//            enabled samples (FILT == 0 bypasses it), registered edge pulses.
// Ports    :
//   CLK      in  clock, rising edge
//   RST      in  synchronous active-high reset
//   en       in  filter sample-enable tick
//   din      in  asynchronous raw level
//   dout     out filtered, synchronized level
//   rise     out one-cycle pulse coincident with dout going 0->1
//   fall     out one-cycle pulse coincident with dout going 1->0
//   chg_next out combinational "dout changes on the next edge" flag, used by
//                the top level to build its registered chg output
// Revision : 1.0 - initial release
// ============================================================================
module yj_basic_debounce_ch
  import yj_basic_pkg::*;
#(
  parameter int   STAGES     = 2,
  parameter int   FILT       = 4,
  parameter logic RSTVAL_BIT = 1'b0
) (
  input  wire  CLK,
  input  wire  RST,
  input  wire  en,
  input  wire  din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic chg_next
);

  // Synchronizer chain: a plain shift register with nothing between flops,
  // so every stage gets a full cycle to resolve.
  logic [STAGES-1:0] r_sync;
  logic              w_s;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync <= {STAGES{RSTVAL_BIT}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], din};
    end
  end

  assign w_s = r_sync[STAGES-1];

  logic  r_dout;
  logic  r_rise;
  logic  r_fall;
  logic  w_dout_next;
  edge_e w_edge;

  generate
    if (FILT > 0) begin : g_filt
      localparam int CW = clog2(FILT + 1);

      logic [CW-1:0] r_cnt;
      logic [CW-1:0] w_cnt_next;

      // Any return of s to dout clears the count, so partial counts from an
      // earlier excursion never help a later one. The count tops out at
      // FILT-1 where it either commits or clears, so it cannot wrap.
      always_comb begin
        w_dout_next = r_dout;
        w_cnt_next  = r_cnt;
        if (w_s == r_dout) begin
          w_cnt_next = '0;
        end else if (en) begin
          if (r_cnt == CW'(FILT - 1)) begin
            w_dout_next = w_s;
            w_cnt_next  = '0;
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
      end

      always_ff @(posedge CLK) begin
        if (RST) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= w_cnt_next;
        end
      end
    end else begin : g_bypass
      // Without a filter the enable has no meaning.
      logic w_unused_en;
      assign w_unused_en = en;
      assign w_dout_next = w_s;
    end
  endgenerate

  assign w_edge = edge_of(r_dout, w_dout_next);

  // Edge flops are loaded from the same next-state as dout, so the pulse
  // appears in the very cycle dout first shows the new level. Reset forces
  // dout and the pulses together, so reset never creates an edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_dout <= RSTVAL_BIT;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_dout <= w_dout_next;
      r_rise <= (w_edge == EDGE_RISE);
      r_fall <= (w_edge == EDGE_FALL);
    end
  end

  assign dout     = r_dout;
  assign rise     = r_rise;
  assign fall     = r_fall;
  assign chg_next = (w_edge != EDGE_NONE);

endmodule : yj_basic_debounce_ch
`default_nettype wire

// File: rtl/yj_basic_signal_sync_filter.sv
`default_nettype none
// ============================================================================
// Module   : yj_basic_signal_sync_filter
// Purpose  : NCH-channel synchronizer with per-channel stability filter and
//            edge detection for asynchronous level inputs.
// Ports    :
//   CLK  in  clock, rising edge
//   RST  in  synchronous active-high reset
//   bus  slave modport of yj_basic_signal_sync_filter_if:
//        en, din in; dout, rise, fall, chg out
// Parameters:
//   NCH    channel count
//   STAGES synchronizer depth, 2..4
//   FILT   stability threshold in enabled samples, 0 = bypass, 0..255
//   RSTVAL per-channel reset level of the sync chain and dout
// Revision : 1.0 - initial release
// ============================================================================
module yj_basic_signal_sync_filter
  import yj_basic_pkg::*;
#(
  parameter int             NCH    = 8,
  parameter int             STAGES = 2,
  parameter int             FILT   = 4,
  parameter logic [NCH-1:0] RSTVAL = {NCH{1'b0}}
) (
  input  wire                          CLK,
  input  wire                          RST,
  yj_basic_signal_sync_filter_if.slave bus
);

  generate
    if (!stages_legal(STAGES)) begin : g_err_stages
      $error("yj_basic_signal_sync_filter: STAGES=%0d outside 2..4", STAGES);
    end
    if (!filt_legal(FILT)) begin : g_err_filt
      $error("yj_basic_signal_sync_filter: FILT=%0d outside 0..255", FILT);
    end
  endgenerate

  logic [NCH-1:0] w_dout;
  logic [NCH-1:0] w_rise;
  logic [NCH-1:0] w_fall;
  logic [NCH-1:0] w_chg_next;
  logic           r_chg;

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      yj_basic_debounce_ch #(
        .STAGES     (STAGES),
        .FILT       (FILT),
        .RSTVAL_BIT (RSTVAL[i])
      ) u_ch (
        .CLK      (CLK),
        .RST      (RST),
        .en       (bus.en),
        .din      (bus.din[i]),
        .dout     (w_dout[i]),
        .rise     (w_rise[i]),
        .fall     (w_fall[i]),
        .chg_next (w_chg_next[i])
      );
    end
  endgenerate

  // Registered from the channels' next-state comparison rather than from
  // the registered pulses, so chg lines up with rise/fall instead of
  // trailing them by a cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_chg <= 1'b0;
    end else begin
      r_chg <= |w_chg_next;
    end
  end

  assign bus.dout = w_dout;
  assign bus.rise = w_rise;
  assign bus.fall = w_fall;
  assign bus.chg  = r_chg;

endmodule : yj_basic_signal_sync_filter
`default_nettype wire

// File: tb/tb_yj_basic_signal_sync_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_yj_basic_signal_sync_filter
// Purpose  : Self-checking bench. Three instances:
//   dut_a : STAGES=2, FILT=4  - table of cycle vectors (reset, glitch, pulse,
//           simultaneous rise/fall, reset at cnt=FILT-1)
//   dut_b : STAGES=2, FILT=2  - enable-tick sequence
//   dut_c : STAGES=3, FILT=0  - bypass sequence with a delay-line model
// Revision : 1.0 - initial release
// ============================================================================
module tb_yj_basic_signal_sync_filter;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic rst_a, rst_b, rst_c;

  yj_basic_signal_sync_filter_if #(.NCH(8)) bus_a ();
  yj_basic_signal_sync_filter_if #(.NCH(8)) bus_b ();
  yj_basic_signal_sync_filter_if #(.NCH(8)) bus_c ();

  yj_basic_signal_sync_filter #(.NCH(8), .STAGES(2), .FILT(4), .RSTVAL(8'h00)) dut_a (
    .CLK (CLK), .RST (rst_a), .bus (bus_a.slave)
  );
  yj_basic_signal_sync_filter #(.NCH(8), .STAGES(2), .FILT(2), .RSTVAL(8'h00)) dut_b (
    .CLK (CLK), .RST (rst_b), .bus (bus_b.slave)
  );
  yj_basic_signal_sync_filter #(.NCH(8), .STAGES(3), .FILT(0), .RSTVAL(8'h00)) dut_c (
    .CLK (CLK), .RST (rst_c), .bus (bus_c.slave)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] din;
    logic [7:0] dout;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       chg;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic void add(input logic r, input logic e, input logic [7:0] d,
                              input logic [7:0] q, input logic [7:0] rs,
                              input logic [7:0] fl, input logic c);
    vec_t v;
    v.rst = r; v.en = e; v.din = d; v.dout = q; v.rise = rs; v.fall = fl; v.chg = c;
    vecs.push_back(v);
  endfunction

  function automatic void add_n(input int n, input logic r, input logic e,
                                input logic [7:0] d, input logic [7:0] q,
                                input logic [7:0] rs, input logic [7:0] fl,
                                input logic c);
    for (int k = 0; k < n; k++) add(r, e, d, q, rs, fl, c);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [7:0] act,
                     input logic [7:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  logic [7:0] pat [0:11] = '{8'h01, 8'h03, 8'h03, 8'h02, 8'h00, 8'hFF,
                             8'hF0, 8'h0F, 8'h0F, 8'hAA, 8'h55, 8'h55};
  logic [7:0] hist [0:31];

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    bus_a.en = 1'b1; bus_a.din = 8'h00;
    bus_b.en = 1'b0; bus_b.din = 8'h00;
    bus_c.en = 1'b0; bus_c.din = 8'h00;

    // ---- vector table for dut_a (STAGES=2, FILT=4) ----
    // reset with din=FF, then dout=FF on the 6th edge after release
    add_n(3, 1, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 0);
    add_n(5, 0, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 0);
    add(0, 1, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1);
    add(0, 1, 8'hFF, 8'hFF, 8'h00, 8'h00, 0);
    // FF -> 04: every channel except 2 falls
    add_n(5, 0, 1, 8'h04, 8'hFF, 8'h00, 8'h00, 0);
    add(0, 1, 8'h04, 8'h04, 8'h00, 8'hFB, 1);
    add(0, 1, 8'h04, 8'h04, 8'h00, 8'h00, 0);
    // 3-cycle glitch on channel 0 is rejected
    add_n(3, 0, 1, 8'h05, 8'h04, 8'h00, 8'h00, 0);
    add_n(6, 0, 1, 8'h04, 8'h04, 8'h00, 8'h00, 0);
    // 4-cycle pulse on channel 0 is accepted; fall 4 cycles after s drops
    add_n(4, 0, 1, 8'h05, 8'h04, 8'h00, 8'h00, 0);
    add(0, 1, 8'h04, 8'h04, 8'h00, 8'h00, 0);
    add(0, 1, 8'h04, 8'h05, 8'h01, 8'h00, 1);
    add_n(3, 0, 1, 8'h04, 8'h05, 8'h00, 8'h00, 0);
    add(0, 1, 8'h04, 8'h04, 8'h00, 8'h01, 1);
    add(0, 1, 8'h04, 8'h04, 8'h00, 8'h00, 0);
    // channel 1 rises while channel 2 falls
    add_n(5, 0, 1, 8'h02, 8'h04, 8'h00, 8'h00, 0);
    add(0, 1, 8'h02, 8'h02, 8'h02, 8'h04, 1);
    add(0, 1, 8'h02, 8'h02, 8'h00, 8'h00, 0);
    // reset lands when cnt == FILT-1: no update, no pulse; then one rise
    add_n(5, 0, 1, 8'h03, 8'h02, 8'h00, 8'h00, 0);
    add(1, 1, 8'h03, 8'h00, 8'h00, 8'h00, 0);
    add_n(5, 0, 1, 8'h03, 8'h00, 8'h00, 8'h00, 0);
    add(0, 1, 8'h03, 8'h03, 8'h03, 8'h00, 1);
    add(0, 1, 8'h03, 8'h03, 8'h00, 8'h00, 0);

    foreach (vecs[i]) begin
      rst_a     = vecs[i].rst;
      bus_a.en  = vecs[i].en;
      bus_a.din = vecs[i].din;
      step();
      n_vec++;
      chk("a_dout", i, bus_a.dout, vecs[i].dout);
      chk("a_rise", i, bus_a.rise, vecs[i].rise);
      chk("a_fall", i, bus_a.fall, vecs[i].fall);
      chk("a_chg",  i, {7'd0, bus_a.chg}, {7'd0, vecs[i].chg});
    end

    // ---- enable tick on dut_b (FILT=2): en high on every 4th edge ----
    step(); step();
    n_vec++;
    chk("b_reset_dout", 0, bus_b.dout, 8'h00);
    rst_b = 1'b0;
    bus_b.din = 8'h08;
    for (int t = 1; t <= 9; t++) begin
      bus_b.en = ((t % 4) == 3);
      step();
      n_vec++;
      // capture on edge 1, s valid after edge 2, enabled samples on edges 3, 7
      chk("b_dout", t, bus_b.dout, (t >= 7) ? 8'h08 : 8'h00);
      chk("b_rise", t, bus_b.rise, (t == 7) ? 8'h08 : 8'h00);
      chk("b_fall", t, bus_b.fall, 8'h00);
      chk("b_chg",  t, {7'd0, bus_b.chg}, (t == 7) ? 8'h01 : 8'h00);
    end

    // ---- bypass on dut_c (STAGES=3, FILT=0): dout = din from 3 edges back ----
    n_vec++;
    chk("c_reset_dout", 0, bus_c.dout, 8'h00);
    rst_c = 1'b0;
    for (int k = 0; k < 32; k++) hist[k] = 8'h00;
    for (int k = 1; k <= 16; k++) begin
      logic [7:0] e_q, e_p, e_r, e_f;
      bus_c.din = (k <= 12) ? pat[k-1] : pat[11];
      bus_c.en  = k[0];
      hist[k]   = bus_c.din;
      step();
      e_q = (k > 3) ? hist[k-3] : 8'h00;
      e_p = (k > 4) ? hist[k-4] : 8'h00;
      e_r = ~e_p & e_q;
      e_f = e_p & ~e_q;
      n_vec++;
      chk("c_dout", k, bus_c.dout, e_q);
      chk("c_rise", k, bus_c.rise, e_r);
      chk("c_fall", k, bus_c.fall, e_f);
      chk("c_chg",  k, {7'd0, bus_c.chg}, {7'd0, |(e_r | e_f)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_yj_basic_signal_sync_filter
`default_nettype wire

// File: doc/yj_basic_signal_sync_filter.md
# yj_basic_signal_sync_filter

Multi-channel synchronizer for asynchronous level inputs such as buttons, straps, interrupt lines and handshake flags entering the PL clock domain. Each channel has a configurable-depth synchronizer chain, a stability filter and edge detection. It is the parametrised successor of the fixed two-flop signal synchronizer. It sits at the PL input boundary, ahead of any logic that consumes external levels or needs clean single-cycle change events.

## Interface
Parameters:
- NCH, 8: number of independent channels.
- STAGES, 2: synchronizer flops per channel; legal range 2..4.
- FILT, 4: consecutive enabled samples a new level must hold before `dout` follows it; 0 bypasses the filter; legal range 0..255.
- RSTVAL, {NCH{1'b0}}: per-channel reset level for the sync chain and `dout`.

Ports:
- CLK, input, 1: single clock; all state updates on the rising edge.
- RST, input, 1: reset. One clock; reset is synchronous and active-high.
- en, input, 1: sample-enable tick for the filter counters; tie to 1 to count every cycle.
- din, input, NCH: asynchronous raw inputs.
- dout, output, NCH: filtered, synchronized level.
- rise, output, NCH: one-cycle pulse when `dout[i]` goes 0→1.
- fall, output, NCH: one-cycle pulse when `dout[i]` goes 1→0.
- chg, output, 1: OR-reduction of `rise | fall`, registered.

## Operation
- Sync chain, per channel: `STAGES` flops in series; `s[i]` is the last flop's output. No logic sits between the chain flops.
- Filter, FILT > 0: per-channel counter `cnt`, width `CW = clog2(FILT+1)`. Each cycle:
  - If `s == dout`: `cnt <= 0`.
  - Else if `en` and `cnt == FILT-1`: `dout <= s`, `cnt <= 0`, and the matching `rise`/`fall` bit goes to 1.
  - Else if `en`: `cnt <= cnt + 1`.
  - Else: `cnt` holds.
- Glitch rejection: if `s` returns to `dout` before the threshold, `cnt` clears. Partial counts never carry over to a later excursion.
- Bypass, FILT == 0: `dout <= s` every cycle. `en` is ignored. No counter is instantiated.
- Edges: `rise <= ~dout & next_dout` and `fall <= dout & ~next_dout`, both registered. They are asserted in the same cycle `dout` first shows the new value, and only for that cycle.
- `chg` is registered from the same `next_dout`/`dout` comparison, so it is coincident with `rise`/`fall`.
- Counter width: `cnt` never exceeds FILT-1, so no wrap-around is possible.
- Channels are fully independent. Any mix of simultaneous rise and fall across channels is legal.

## Timing
- Reset values: while `RST` is 1 at a clock edge:
  - sync flops ← RSTVAL, `dout` ← RSTVAL;
  - `cnt` ← 0;
  - `rise`, `fall`, `chg` ← 0.
- Reset has priority over every other update. Asserting `RST` mid-count discards the count. No edge pulse is generated by reset entry or exit.
- After `RST` deasserts, a `din` that differs from RSTVAL passes through the normal sync and filter path. It produces exactly one edge pulse.
- Latency with `en` held at 1 and `din` stable: `dout` changes `STAGES + FILT` rising edges after the first edge that captures the new `din`. With FILT=0 it is `STAGES + 1`.
- With `en` as a tick of period P: filter latency is FILT enabled samples, so up to FILT·P cycles plus the sync delay.
- Minimum accepted pulse width on `din`: FILT enabled samples.
- Metastability: only the first chain flop may go metastable. The design provides a full cycle of settling per stage.

## Structure
- Shared package/include `yj_basic_pkg`:
  - `clog2` function used to size `CW`;
  - legal-range checks for STAGES and FILT, as elaboration-time errors.
- Sub-module `yj_basic_debounce_ch`: one channel with sync chain, counter, `dout` and edge flops; parameters STAGES, FILT, RSTVAL_BIT.
- Top level: a generate loop over NCH instances plus the `chg` register.

## Test plan
- Reset: NCH=8, `din`=8'hFF held, RSTVAL=0, RST high for 3 cycles. While RST is high, all outputs are 0. After release, with STAGES=2 and FILT=4, `dout`=8'hFF exactly 6 edges later. `rise`=8'hFF for one cycle and `chg`=1 in that same cycle.
- Glitch: channel 0 `din` pulses high for 3 cycles, FILT=4, en=1. `dout[0]` stays 0 and no pulses occur. A 4-cycle pulse produces `rise[0]`, then `fall[0]` 4 cycles after `s` drops.
- Enable tick: `en` high every 4th cycle, FILT=2, step on channel 3. `dout[3]` updates only after 2 enabled samples. `cnt` holds while `en`=0.
- Bypass: FILT=0, STAGES=3, toggling input. `dout` equals `din` delayed 4 cycles. `rise`/`fall` fire on each transition.
- Simultaneous events and reset: channel 1 rises while channel 2 falls in the same cycle, giving `rise`=8'h02, `fall`=8'h04, `chg`=1. Asserting RST at `cnt`=FILT-1 gives no update and no pulse.
